// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM unified-memory port arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  localparam int DEF_MAX_STARVE = 4;
  localparam int DEF_TIMEOUT    = 16;
  localparam int DEF_CW         = 5;

  // Memory is word-addressed on the downstream side; byte offset is dropped.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear (clear wins over increment).
// Latency: count updates one cycle after inc/clr.
// Backpressure: none; holds at all-ones instead of wrapping.
module sat_counter #(
  parameter int CW = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_inc,
  input  logic          i_clr,
  output logic [CW-1:0] o_cnt
);

  localparam logic [CW-1:0] MAX_VAL = '1;

  logic [CW-1:0] r_cnt;

  // Count register: clear has priority, increment stops at the maximum.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != MAX_VAL)) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetches and MEM loads/stores onto one single-port memory (DM priority, IF anti-starvation).
// Latency: request sampled at edge E, mem_req from E, ready pulse the cycle after mem_ack (min 2 cycles).
// Backpressure: requesters hold req until their one-cycle ready pulse; one access outstanding; hung accesses time out.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_STARVE = DEF_MAX_STARVE,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CW         = DEF_CW
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_ready,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_ready,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        owner,
  output logic        bus_err
);

  state_t r_state;
  state_t w_state_nxt;

  logic w_grant_dm;
  logic w_grant_if;
  logic w_done_ack;
  logic w_done_to;
  logic w_done;

  logic [CW-1:0] w_starve_cnt;
  logic [CW-1:0] w_to_cnt;
  logic          w_starve_inc;
  logic          w_starve_clr;
  logic          w_to_inc;
  logic          w_to_clr;

  logic        r_mem_req;
  logic        r_mem_we;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic        r_owner;
  logic        r_if_ready;
  logic        r_dm_ready;
  logic [31:0] r_if_rdata;
  logic [31:0] r_dm_rdata;
  logic        r_bus_err;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus grant/completion decode; mem_ack outside BUSY is ignored.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_dm  = 1'b0;
    w_grant_if  = 1'b0;
    w_done_ack  = 1'b0;
    w_done_to   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // IF is forced through once DM has won MAX_STARVE times in a row over it.
        if (dm_req && !(if_req && (w_starve_cnt == CW'(MAX_STARVE)))) begin
          w_grant_dm  = 1'b1;
          w_state_nxt = ST_BUSY;
        end else if (if_req) begin
          w_grant_if  = 1'b1;
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          w_done_ack  = 1'b1;
          w_state_nxt = ST_RESP;
        end else if (w_to_cnt == CW'(TIMEOUT - 1)) begin
          w_done_to   = 1'b1;
          w_state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign w_done = w_done_ack | w_done_to;

  assign w_starve_inc = w_grant_dm & if_req;
  assign w_starve_clr = (w_grant_dm & ~if_req) | w_grant_if;
  assign w_to_clr     = w_grant_dm | w_grant_if;
  assign w_to_inc     = (r_state == ST_BUSY) & ~w_done;

  sat_counter #(.CW(CW)) u_starve_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_starve_inc),
    .i_clr (w_starve_clr),
    .o_cnt (w_starve_cnt)
  );

  sat_counter #(.CW(CW)) u_to_cnt (
    .clk   (clk),
    .rst   (rst),
    .i_inc (w_to_inc),
    .i_clr (w_to_clr),
    .o_cnt (w_to_cnt)
  );

  // Downstream request side: latch the winner's access and hold it until completion.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_owner     <= OWN_IF;
    end else if (w_grant_dm) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= dm_we;
      r_mem_addr  <= word_align(dm_addr);
      r_mem_wdata <= dm_wdata;
      r_owner     <= OWN_DM;
    end else if (w_grant_if) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= word_align(if_addr);
      r_mem_wdata <= '0;
      r_owner     <= OWN_IF;
    end else if (w_done) begin
      r_mem_req   <= 1'b0;
    end
  end

  // Response side: one-cycle ready to the owner; a timed-out access returns zero data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      r_if_rdata <= '0;
      r_dm_rdata <= '0;
    end else begin
      r_if_ready <= 1'b0;
      r_dm_ready <= 1'b0;
      if (w_done) begin
        if (r_owner == OWN_DM) begin
          r_dm_ready <= 1'b1;
          r_dm_rdata <= w_done_ack ? mem_rdata : 32'h0;
        end else begin
          r_if_ready <= 1'b1;
          r_if_rdata <= w_done_ack ? mem_rdata : 32'h0;
        end
      end
    end
  end

  // Sticky error flag: only reset clears a recorded timeout.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bus_err <= 1'b0;
    end else if (w_done_to) begin
      r_bus_err <= 1'b1;
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign owner     = r_owner;
  assign if_ready  = r_if_ready;
  assign dm_ready  = r_dm_ready;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign bus_err   = r_bus_err;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Latency: a behavioural memory acks after a programmable number of BUSY cycles.
// Backpressure: requests are held until the matching ready pulse is observed.
module tb_mem_port_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        owner;
  logic        bus_err;

  int n_chk = 0;
  int n_err = 0;

  // Memory responder controls.
  logic        r_ack     = 1'b0;
  logic        stray_ack = 1'b0;
  bit          ack_en    = 1'b1;
  int          ack_delay = 1;
  int          busy_n    = 0;
  logic [31:0] resp_data = 32'h0;

  assign mem_ack = r_ack | stray_ack;

  mem_port_arbiter #(
    .MAX_STARVE (4),
    .TIMEOUT    (16),
    .CW         (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_rdata  (if_rdata),
    .if_ready  (if_ready),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_rdata  (dm_rdata),
    .dm_ready  (dm_ready),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ack   (mem_ack),
    .owner     (owner),
    .bus_err   (bus_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural memory: ack in BUSY cycle number ack_delay of each access.
  always @(negedge clk) begin
    r_ack = 1'b0;
    if (mem_req && ack_en) begin
      busy_n = busy_n + 1;
      if (busy_n == ack_delay) begin
        r_ack     = 1'b1;
        mem_rdata = resp_data;
      end
    end else begin
      busy_n = 0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Wait (bounded) for mem_req to be seen high at a falling edge.
  task automatic wait_grant(input string tag, output int cyc);
    cyc = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      cyc++;
      if (mem_req) break;
    end
    chk({tag, "_grant"}, {31'h0, mem_req}, 32'h1);
  endtask

  // Wait (bounded) for the wanted ready; the other ready must stay low meanwhile.
  task automatic wait_ready(input string tag, input logic want_dm, output int cyc);
    logic other;
    other = 1'b0;
    cyc   = 0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      cyc++;
      if (want_dm ? if_ready : dm_ready) other = 1'b1;
      if (want_dm ? dm_ready : if_ready) break;
    end
    chk({tag, "_rdy"}, {31'h0, (want_dm ? dm_ready : if_ready)}, 32'h1);
    chk({tag, "_other_rdy"}, {31'h0, other}, 32'h0);
  endtask

  initial begin
    int g;
    int r;
    int cnt;
    logic flag;
    logic exp_own;

    rst      = 1'b0;
    if_req   = 1'b0;
    if_addr  = 32'h0;
    dm_req   = 1'b0;
    dm_we    = 1'b0;
    dm_addr  = 32'h0;
    dm_wdata = 32'h0;

    // Reset state.
    @(negedge clk);
    @(negedge clk);
    chk("rst_mem_req",  {31'h0, mem_req},  32'h0);
    chk("rst_if_ready", {31'h0, if_ready}, 32'h0);
    chk("rst_dm_ready", {31'h0, dm_ready}, 32'h0);
    chk("rst_owner",    {31'h0, owner},    32'h0);
    chk("rst_bus_err",  {31'h0, bus_err},  32'h0);
    chk("rst_if_rdata", if_rdata, 32'h0);
    chk("rst_dm_rdata", dm_rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    rst = 1'b1;

    // 1: IF-only fetch, minimum-latency ack.
    @(negedge clk);
    ack_delay = 1;
    resp_data = 32'h2008_0005;
    if_addr   = 32'h0000_3000;
    if_req    = 1'b1;
    wait_grant("t1", g);
    chk("t1_mem_addr", mem_addr, 32'h0000_3000);
    chk("t1_mem_we",   {31'h0, mem_we}, 32'h0);
    chk("t1_owner",    {31'h0, owner},  32'h0);
    wait_ready("t1", 1'b0, r);
    chk("t1_latency", g + r, 2);
    chk("t1_if_rdata", if_rdata, 32'h2008_0005);
    chk("t1_mem_req_low", {31'h0, mem_req}, 32'h0);
    if_req = 1'b0;
    @(negedge clk);
    chk("t1_rdy_one_cycle", {31'h0, if_ready}, 32'h0);

    // 2: simultaneous store and fetch, DM first then IF.
    dm_req    = 1'b1;
    dm_we     = 1'b1;
    dm_addr   = 32'h0000_0054;
    dm_wdata  = 32'h0000_000B;
    if_req    = 1'b1;
    if_addr   = 32'h0000_3000;
    resp_data = 32'hDEAD_0001;
    wait_grant("t2a", g);
    chk("t2_owner_dm",  {31'h0, owner},  32'h1);
    chk("t2_mem_we",    {31'h0, mem_we}, 32'h1);
    chk("t2_mem_addr",  mem_addr,  32'h0000_0054);
    chk("t2_mem_wdata", mem_wdata, 32'h0000_000B);
    wait_ready("t2a", 1'b1, r);
    dm_req    = 1'b0;
    dm_we     = 1'b0;
    resp_data = 32'h0000_1111;
    wait_grant("t2b", g);
    chk("t2_owner_if",     {31'h0, owner},  32'h0);
    chk("t2_if_mem_we",    {31'h0, mem_we}, 32'h0);
    chk("t2_if_mem_wdata", mem_wdata, 32'h0);
    chk("t2_if_mem_addr",  mem_addr,  32'h0000_3000);
    wait_ready("t2b", 1'b0, r);
    chk("t2_if_rdata", if_rdata, 32'h0000_1111);
    if_req = 1'b0;

    // 3: both held; IF forced after every 4 consecutive DM grants.
    dm_addr   = 32'h0000_0080;
    dm_req    = 1'b1;
    if_req    = 1'b1;
    resp_data = 32'h0000_0055;
    for (int i = 0; i < 10; i++) begin
      exp_own = (i % 5 == 4) ? 1'b0 : 1'b1;
      wait_grant($sformatf("t3_%0d", i), g);
      chk($sformatf("t3_owner_%0d", i), {31'h0, owner}, {31'h0, exp_own});
      wait_ready($sformatf("t3_%0d", i), exp_own, r);
    end
    dm_req = 1'b0;
    if_req = 1'b0;

    // 4: no ack -> timeout after 16 BUSY cycles; bus_err sticks.
    @(negedge clk);
    ack_en  = 1'b0;
    dm_addr = 32'h0000_0100;
    dm_req  = 1'b1;
    wait_grant("t4", g);
    chk("t4_bus_err_pre", {31'h0, bus_err}, 32'h0);
    cnt = 1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!mem_req) break;
      cnt++;
    end
    chk("t4_busy_cycles", cnt, 16);
    chk("t4_dm_ready",    {31'h0, dm_ready}, 32'h1);
    chk("t4_dm_rdata",    dm_rdata, 32'h0);
    chk("t4_bus_err",     {31'h0, bus_err}, 32'h1);
    dm_req    = 1'b0;
    ack_en    = 1'b1;
    resp_data = 32'h1234_5678;
    if_addr   = 32'h0000_3008;
    if_req    = 1'b1;
    wait_grant("t4b", g);
    wait_ready("t4b", 1'b0, r);
    chk("t4_if_rdata",     if_rdata, 32'h1234_5678);
    chk("t4_bus_err_held", {31'h0, bus_err}, 32'h1);
    if_req = 1'b0;

    // 5: asynchronous reset in the middle of a BUSY access.
    @(negedge clk);
    ack_delay = 5;
    if_addr   = 32'h0000_300C;
    if_req    = 1'b1;
    wait_grant("t5", g);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("t5_mem_req",  {31'h0, mem_req},  32'h0);
    chk("t5_if_ready", {31'h0, if_ready}, 32'h0);
    chk("t5_dm_ready", {31'h0, dm_ready}, 32'h0);
    chk("t5_bus_err",  {31'h0, bus_err},  32'h0);
    chk("t5_if_rdata", if_rdata, 32'h0);
    if_req = 1'b0;
    @(negedge clk);
    rst       = 1'b1;
    ack_delay = 1;
    flag      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (if_ready || dm_ready || mem_req) flag = 1'b1;
    end
    chk("t5_no_stale", {31'h0, flag}, 32'h0);
    resp_data = 32'hCAFE_0001;
    if_addr   = 32'h0000_3010;
    if_req    = 1'b1;
    wait_grant("t5b", g);
    chk("t5_mem_addr", mem_addr, 32'h0000_3010);
    wait_ready("t5b", 1'b0, r);
    chk("t5_latency",  g + r, 2);
    chk("t5_if_rdata", if_rdata, 32'hCAFE_0001);
    if_req = 1'b0;

    // 6: stray acks in IDLE and RESP are ignored; address is word-aligned.
    @(negedge clk);
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    chk("t6_idle_if_ready", {31'h0, if_ready}, 32'h0);
    chk("t6_idle_dm_ready", {31'h0, dm_ready}, 32'h0);
    chk("t6_idle_mem_req",  {31'h0, mem_req},  32'h0);
    @(negedge clk);
    chk("t6_idle_ready2", {31'h0, (if_ready | dm_ready)}, 32'h0);
    resp_data = 32'h0BAD_F00D;
    if_addr   = 32'h0000_3003;
    if_req    = 1'b1;
    wait_grant("t6", g);
    chk("t6_mem_addr", mem_addr, 32'h0000_3000);
    wait_ready("t6", 1'b0, r);
    chk("t6_if_rdata", if_rdata, 32'h0BAD_F00D);
    if_req    = 1'b0;
    stray_ack = 1'b1;
    @(negedge clk);
    stray_ack = 1'b0;
    chk("t6_resp_if_ready", {31'h0, if_ready}, 32'h0);
    chk("t6_resp_mem_req",  {31'h0, mem_req},  32'h0);
    @(negedge clk);
    chk("t6_after_ready", {31'h0, (if_ready | dm_ready | mem_req)}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
